ssd_bcd_scanner: RTL and testbench
==================================

SSD_BCD_SCANNER -- requirements
Module: ssd_bcd_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000 (integer >= 2): CLK cycles per displayed digit.
REQ-002 SHALL have port CLK, input, 1, system clock; all state on rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port data_in, input, 16, signed two's-complement value to display.
REQ-005 SHALL have port load, input, 1, one-cycle strobe starting a conversion of data_in.
REQ-006 SHALL have port temp_mode, input, 1, sampled with load; selects temperature format.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when new digits are committed.
REQ-009 SHALL have port num_out, output, 4, digit code for the active digit: 0-9 numerals, 0xA blank, 0xB 'C', 0xC minus.
REQ-010 SHALL have port control, output, 2, index of the active digit; 0 = rightmost.
REQ-011 SHALL have port anode, output, 4, active-low digit enables; anode[i] low only when control == i.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, DONE.
REQ-013 SHALL accept load only when busy = 0 (IDLE or DONE); load while busy = 1 SHALL be ignored without side effect.
REQ-014 SHALL, on an accepted load, capture data_in and temp_mode, form magnitude |data_in| as 16-bit unsigned (-32768 -> 32768), and enter CONV.
REQ-015 SHALL in CONV perform sequential double-dabble, one bit per cycle, exactly 16 cycles, producing 5 BCD digits.
REQ-016 SHALL, with load accepted at edge k, hold busy = 1 for cycles k+1..k+16, assert done = 1 for cycle k+17 only (state DONE), and update the display registers on the same edge that raises done.
REQ-017 SHALL in normal format (temp_mode = 0) saturate magnitude > 999 to 999; digits 3..0 = sign, hundreds, tens, ones.
REQ-018 SHALL in temperature format (temp_mode = 1) saturate magnitude > 99 to 99; digits 3..0 = sign, tens, ones, 0xB.
REQ-019 SHALL set the sign digit to 0xC for negative data_in and to 0xA otherwise; zero is non-negative.
REQ-020 SHALL keep the previously committed digits on display throughout CONV (atomic update).
REQ-021 SHALL run a free-running prescaler of 0..REFRESH_DIV-1; on wrap, control SHALL advance 0->1->2->3->0.
REQ-022 SHALL drive num_out, control and anode from registers so that all three change on the same edge.
REQ-023 SHALL leave scanning unaffected by load, busy and done.

Reset
REQ-024 SHALL, while RST = 1, force: state IDLE, busy 0, done 0, prescaler 0, control 0, anode 4'b1110, all four display registers 0xA, num_out 0xA.
REQ-025 SHALL, if RST asserts mid-conversion, abort it: no done pulse, display registers remain blank after release.
REQ-026 SHALL accept a load in the first cycle after RST deasserts.

Configuration
REQ-027 SHALL, when macro SSD_LZ_BLANK_EN is defined, replace leading zero numeral digits (hundreds, then tens) with 0xA; the ones digit always shows a numeral, and the sign digit stays in digit 3.
REQ-028 SHALL, when SSD_LZ_BLANK_EN is undefined, show all numeral digits including leading zeros.

Verification
REQ-029 SHALL cover: load data_in=123, temp_mode=0 -> busy 16 cycles, done at k+17, digits3..0 = A,1,2,3.
REQ-030 SHALL cover: data_in=-45 (0xFFD3) -> digits C,0,4,5 without SSD_LZ_BLANK_EN; C,A,4,5 with it.
REQ-031 SHALL cover: data_in=5000 -> A,9,9,9; data_in=-32768 -> C,9,9,9; temp_mode=1 with 25 -> A,2,5,B; temp_mode=1 with -150 -> C,9,9,B.
REQ-032 SHALL cover: second load during busy -> ignored, single done, digits of first value; RST at cycle k+8 -> no done, all digits A.
REQ-033 SHALL cover: REFRESH_DIV=4 -> anode sequence 1110,1101,1011,0111 repeating, each held 4 cycles, num_out matching digit control.

Source files
------------

// File: rtl/ssd_bcd_scanner.sv
// Signed 16-bit value to 4-digit multiplexed 7-seg codes via sequential double-dabble.
// Define SSD_LZ_BLANK_EN to blank leading zero numerals (hundreds, then tens).
module ssd_bcd_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        temp_mode,
  output logic        busy,
  output logic        done,
  output logic [3:0]  num_out,
  output logic [1:0]  control,
  output logic [3:0]  anode
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] D_BLANK = 4'hA;
  localparam logic [3:0] D_C     = 4'hB;
  localparam logic [3:0] D_MINUS = 4'hC;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [15:0]     bin;
  logic [19:0]     bcd;
  logic [3:0]      bit_cnt;
  logic            tmode;
  logic            neg;
  logic [3:0][3:0] disp;
  logic [3:0][3:0] disp_nxt;
  logic [3:0][3:0] digits_new;
  logic [PW-1:0]   presc;
  logic [1:0]      ctrl_nxt;
  logic [19:0]     bcd_adj;
  logic [19:0]     bcd_step;
  logic [15:0]     mag;
  logic            commit;

  assign mag    = data_in[15] ? (~data_in + 16'd1) : data_in;
  assign commit = (state == CONV) && (bit_cnt == 4'd15);

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[18:0], bin[15]};
  end

  // Saturate and format the final BCD result into the four display codes.
  always_comb begin
    logic [3:0] sgn, hun, ten, one;
    sgn = neg ? D_MINUS : D_BLANK;
    hun = bcd_step[11:8];
    ten = bcd_step[7:4];
    one = bcd_step[3:0];
    digits_new = '0;
    if (tmode) begin
      if (|bcd_step[19:8]) begin
        ten = 4'd9;
        one = 4'd9;
      end
`ifdef SSD_LZ_BLANK_EN
      if (ten == 4'd0) ten = D_BLANK;
`endif
      digits_new = {sgn, ten, one, D_C};
    end else begin
      if (|bcd_step[19:12]) begin
        hun = 4'd9;
        ten = 4'd9;
        one = 4'd9;
      end
`ifdef SSD_LZ_BLANK_EN
      if (hun == 4'd0) begin
        hun = D_BLANK;
        if (ten == 4'd0) ten = D_BLANK;
      end
`endif
      digits_new = {sgn, hun, ten, one};
    end
  end

  always_comb begin
    disp_nxt = commit ? digits_new : disp;
    ctrl_nxt = (presc == PW'(REFRESH_DIV - 1)) ? control + 2'd1 : control;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      tmode   <= 1'b0;
      neg     <= 1'b0;
      for (int i = 0; i < 4; i++) disp[i] <= D_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            bin     <= mag;
            bcd     <= '0;
            bit_cnt <= '0;
            tmode   <= temp_mode;
            neg     <= data_in[15];
            busy    <= 1'b1;
            state   <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        CONV: begin
          bin     <= {bin[14:0], 1'b0};
          bcd     <= bcd_step;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
      disp <= disp_nxt;
    end
  end

  // Scan outputs all come from registers fed by next-state values so they move together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      control <= 2'd0;
      anode   <= 4'b1110;
      num_out <= D_BLANK;
    end else begin
      presc   <= (presc == PW'(REFRESH_DIV - 1)) ? '0 : presc + PW'(1);
      control <= ctrl_nxt;
      anode   <= ~(4'b0001 << ctrl_nxt);
      num_out <= disp_nxt[ctrl_nxt];
    end
  end

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Directed bench for ssd_bcd_scanner with a fast refresh divider.
module tb_ssd_bcd_scanner;

  logic        CLK;
  logic        RST;
  logic [15:0] data_in;
  logic        load;
  logic        temp_mode;
  logic        busy;
  logic        done;
  logic [3:0]  num_out;
  logic [1:0]  control;
  logic [3:0]  anode;

  int n_checks = 0;
  int n_fail   = 0;

  ssd_bcd_scanner #(.REFRESH_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .load(load), .temp_mode(temp_mode),
    .busy(busy), .done(done), .num_out(num_out), .control(control), .anode(anode)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collect the four digit codes by watching one full scan period.
  task automatic read_disp(input string tag, input logic [15:0] exp);
    logic [15:0] seen;
    seen = 16'hFFFF;
    repeat (16) begin
      @(negedge CLK);
      seen[{control, 2'b00} +: 4] = num_out;
    end
    check_eq(tag, {16'h0, seen}, {16'h0, exp});
  endtask

  // Entered just after a negedge; load is accepted on the next posedge.
  task automatic conv(input string tag, input logic [15:0] v, input logic tm, input logic [15:0] exp);
    int cyc, nb;
    data_in   = v;
    temp_mode = tm;
    load      = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
    cyc = 0;
    nb  = 0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (busy) nb++;
    end
    check_eq({tag, "_done_lat"}, cyc, 17);
    check_eq({tag, "_busy_len"}, nb, 16);
    @(negedge CLK);
    check_eq({tag, "_done_1cyc"}, {31'h0, done}, 0);
    read_disp({tag, "_digits"}, exp);
  endtask

  initial begin
    int nd;
    RST       = 1'b1;
    load      = 1'b0;
    data_in   = 16'h0;
    temp_mode = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_busy", {31'h0, busy}, 0);
    check_eq("rst_done", {31'h0, done}, 0);
    check_eq("rst_control", {30'h0, control}, 0);
    check_eq("rst_anode", {28'h0, anode}, 32'he);
    check_eq("rst_num_out", {28'h0, num_out}, 32'ha);
    RST = 1'b0;

    // Scan sequence: each anode held 4 cycles, display still blank.
    for (int n = 1; n <= 32; n++) begin
      logic [1:0] ec;
      @(negedge CLK);
      ec = 2'((n / 4) % 4);
      check_eq("scan_control", {30'h0, control}, {30'h0, ec});
      check_eq("scan_anode", {28'h0, anode}, {28'h0, ~(4'b0001 << ec)});
      check_eq("scan_num_out", {28'h0, num_out}, 32'ha);
    end

    conv("p123", 16'd123, 1'b0, 16'hA123);
`ifdef SSD_LZ_BLANK_EN
    conv("m45", 16'hFFD3, 1'b0, 16'hCA45);
    conv("zero", 16'd0, 1'b0, 16'hAAA0);
`else
    conv("m45", 16'hFFD3, 1'b0, 16'hC045);
    conv("zero", 16'd0, 1'b0, 16'hA000);
`endif
    conv("p5000", 16'd5000, 1'b0, 16'hA999);
    conv("m32768", 16'h8000, 1'b0, 16'hC999);
    conv("t25", 16'd25, 1'b1, 16'hA25B);
    conv("tm150", 16'hFF6A, 1'b1, 16'hC99B);

    // Second load while busy must be ignored.
    data_in = 16'd123; temp_mode = 1'b0; load = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
    nd = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge CLK);
      if (done) nd++;
      if (i == 5) begin data_in = 16'd456; load = 1'b1; end
      if (i == 6) load = 1'b0;
    end
    check_eq("ign_done_cnt", nd, 1);
    read_disp("ign_digits", 16'hA123);

    // Reset mid-conversion aborts and blanks.
    data_in = 16'd77; load = 1'b1;
    @(posedge CLK);
    #1 load = 1'b0;
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    #1 check_eq("abort_busy", {31'h0, busy}, 0);
    @(negedge CLK);
    RST = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done) nd++;
    end
    check_eq("abort_done_cnt", nd, 0);
    read_disp("abort_digits", 16'hAAAA);

    // Load in the very first cycle after reset release.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    conv("post_rst", 16'd25, 1'b1, 16'hA25B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
